// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer.
// Contents: FSM state encoding, ALU operation codes, datapath mux select
// encodings (ALU B source, next-PC, write-data, write-register),
// memory access width codes, and opcode/funct values.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEMRD  = 3'd3,
        ST_MEMWR  = 3'd4,
        ST_WB     = 3'd5,
        ST_MEMWB  = 3'd6
    } state_t;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_XOR  = 4'd7;
    localparam logic [3:0] ALU_NOR  = 4'd8;
    localparam logic [3:0] ALU_SLL  = 4'd9;
    localparam logic [3:0] ALU_SRL  = 4'd10;
    localparam logic [3:0] ALU_SRA  = 4'd11;
    localparam logic [3:0] ALU_LUI  = 4'd12;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JUMP = 2'b10;
    localparam logic [1:0] NPC_JREG = 2'b11;

    localparam logic [1:0] WDSel_ALU = 2'b00;
    localparam logic [1:0] WDSel_MDR = 2'b01;
    localparam logic [1:0] WDSel_PC  = 2'b10;

    localparam logic [1:0] GPRSel_RD = 2'b00;
    localparam logic [1:0] GPRSel_RT = 2'b01;
    localparam logic [1:0] GPRSel_RA = 2'b10;

    localparam logic [1:0] MEMOP_NONE = 2'b00;
    localparam logic [1:0] MEMOP_BW   = 2'b01;
    localparam logic [1:0] MEMOP_H    = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    // States in which the FSM is waiting on the shared memory port.
    function automatic logic is_mem_state(state_t s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Instruction classifier for the multi-cycle sequencer.
// Ports:
//   op, funct   in   opcode / funct fields of the IR
//   alu_r ..    out  one-hot instruction class (alu_r, alu_i, load, store,
//                    branch, jump, jal, jr, jalr, illegal)
//   br_ne       out  branch is bne (otherwise beq)
//   alu_op      out  ALU operation for the EXEC step
//   ext_op      out  sign-extend the immediate
//   mem_op      out  memory access width code
//   areg_sel    out  shamt drives ALU A (constant shifts)
// Purely combinational.
module mc_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic       alu_r,
    output logic       alu_i,
    output logic       load,
    output logic       store,
    output logic       branch,
    output logic       br_ne,
    output logic       jump,
    output logic       jal,
    output logic       jr,
    output logic       jalr,
    output logic       illegal,
    output logic [3:0] alu_op,
    output logic       ext_op,
    output logic [1:0] mem_op,
    output logic       areg_sel
);

    always_comb begin
        alu_r    = 1'b0;
        alu_i    = 1'b0;
        load     = 1'b0;
        store    = 1'b0;
        branch   = 1'b0;
        br_ne    = 1'b0;
        jump     = 1'b0;
        jal      = 1'b0;
        jr       = 1'b0;
        jalr     = 1'b0;
        illegal  = 1'b0;
        alu_op   = ALU_NOP;
        ext_op   = 1'b0;
        mem_op   = MEMOP_NONE;
        areg_sel = 1'b0;

        case (op)
            OP_RTYPE: begin
                alu_r = 1'b1;
                case (funct)
                    F_ADD, F_ADDU: alu_op = ALU_ADD;
                    F_SUB, F_SUBU: alu_op = ALU_SUB;
                    F_AND:         alu_op = ALU_AND;
                    F_OR:          alu_op = ALU_OR;
                    F_XOR:         alu_op = ALU_XOR;
                    F_NOR:         alu_op = ALU_NOR;
                    F_SLT:         alu_op = ALU_SLT;
                    F_SLTU:        alu_op = ALU_SLTU;
                    F_SLL:  begin alu_op = ALU_SLL; areg_sel = 1'b1; end
                    F_SRL:  begin alu_op = ALU_SRL; areg_sel = 1'b1; end
                    F_SRA:  begin alu_op = ALU_SRA; areg_sel = 1'b1; end
                    // Variable shifts take the amount from rs on ALU A.
                    F_SLLV:        alu_op = ALU_SLL;
                    F_SRLV:        alu_op = ALU_SRL;
                    F_SRAV:        alu_op = ALU_SRA;
                    F_JR:   begin alu_r = 1'b0; jr   = 1'b1; end
                    F_JALR: begin alu_r = 1'b0; jalr = 1'b1; end
                    default: begin alu_r = 1'b0; illegal = 1'b1; end
                endcase
            end
            OP_ADDI, OP_ADDIU: begin alu_i = 1'b1; alu_op = ALU_ADD;  ext_op = 1'b1; end
            OP_SLTI:           begin alu_i = 1'b1; alu_op = ALU_SLT;  ext_op = 1'b1; end
            OP_SLTIU:          begin alu_i = 1'b1; alu_op = ALU_SLTU; ext_op = 1'b1; end
            OP_ANDI:           begin alu_i = 1'b1; alu_op = ALU_AND; end
            OP_ORI:            begin alu_i = 1'b1; alu_op = ALU_OR;  end
            OP_XORI:           begin alu_i = 1'b1; alu_op = ALU_XOR; end
            OP_LUI:            begin alu_i = 1'b1; alu_op = ALU_LUI; end
            OP_LB, OP_LBU, OP_LW: begin
                load = 1'b1; alu_op = ALU_ADD; ext_op = 1'b1; mem_op = MEMOP_BW;
            end
            OP_LH, OP_LHU: begin
                load = 1'b1; alu_op = ALU_ADD; ext_op = 1'b1; mem_op = MEMOP_H;
            end
            OP_SB, OP_SW: begin
                store = 1'b1; alu_op = ALU_ADD; ext_op = 1'b1; mem_op = MEMOP_BW;
            end
            OP_SH: begin
                store = 1'b1; alu_op = ALU_ADD; ext_op = 1'b1; mem_op = MEMOP_H;
            end
            OP_BEQ: begin branch = 1'b1; alu_op = ALU_SUB; ext_op = 1'b1; end
            OP_BNE: begin branch = 1'b1; br_ne = 1'b1; alu_op = ALU_SUB; ext_op = 1'b1; end
            OP_J:   jump = 1'b1;
            OP_JAL: jal  = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer for the MIPS core. Steps each instruction
// through fetch/decode/execute/memory/write-back over one shared memory
// port, stalling on mem_ready.
//
// state   | meaning
// --------+-------------------------------------------------------------
// FETCH   | read IR at PC, PC <= PC+4 on mem_ready
// DECODE  | branch target into ALUOut; j/jal complete here
// EXEC    | ALU op / address calc; branches and jr/jalr complete here
// MEMRD   | load read at ALUOut, wait for mem_ready
// MEMWR   | store write at ALUOut, completes on mem_ready
// WB      | ALU result to rd (R-type) or rt (I-type)
// MEMWB   | MDR to rt
//
// Ports: clk, rst (async, active-high); Op/Funct from IR; Zero from ALU;
// mem_ready handshake; datapath strobes (PCWrite .. memOp) decoded
// combinationally from state/Op/Funct; illegal and bus_err one-cycle
// pulses; instret retired-instruction count; state for debug.
module mc_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int MEM_TO = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       ALUOp,
    output logic             EXTOp,
    output logic             AregSel,
    output logic [1:0]       NPCOp,
    output logic [1:0]       GPRSel,
    output logic [1:0]       WDSel,
    output logic [1:0]       memOp,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state
);

    localparam int WAIT_W = (MEM_TO > 2) ? $clog2(MEM_TO) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_TO - 1);

    state_t            state_q;
    state_t            state_d;
    logic [WAIT_W-1:0] wait_left;
    logic              wait_tc;
    logic              retire;

    logic       d_alu_r, d_alu_i, d_load, d_store, d_branch, d_br_ne;
    logic       d_jump, d_jal, d_jr, d_jalr, d_illegal;
    logic [3:0] d_alu_op;
    logic       d_ext_op;
    logic [1:0] d_mem_op;
    logic       d_areg_sel;

    mc_decode u_decode (
        .op       (Op),
        .funct    (Funct),
        .alu_r    (d_alu_r),
        .alu_i    (d_alu_i),
        .load     (d_load),
        .store    (d_store),
        .branch   (d_branch),
        .br_ne    (d_br_ne),
        .jump     (d_jump),
        .jal      (d_jal),
        .jr       (d_jr),
        .jalr     (d_jalr),
        .illegal  (d_illegal),
        .alu_op   (d_alu_op),
        .ext_op   (d_ext_op),
        .mem_op   (d_mem_op),
        .areg_sel (d_areg_sel)
    );

    assign state   = state_q;
    // wait_left counts down the remaining stall cycles; zero means this is
    // the last cycle we tolerate mem_ready low.
    assign wait_tc = (wait_left == '0);

    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_RT;
        ALUOp    = ALU_NOP;
        EXTOp    = 1'b0;
        AregSel  = 1'b0;
        NPCOp    = NPC_PC4;
        GPRSel   = GPRSel_RD;
        WDSel    = WDSel_ALU;
        memOp    = MEMOP_NONE;
        illegal  = 1'b0;
        bus_err  = 1'b0;
        retire   = 1'b0;
        state_d  = state_q;

        case (state_q)
            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_4;
                ALUOp   = ALU_ADD;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = ST_DECODE;
                end else if (wait_tc) begin
                    // PC was not advanced, so staying in FETCH retries the same address.
                    bus_err = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                ALUSrcB = SRCB_IMM_SH;
                ALUOp   = ALU_ADD;
                EXTOp   = 1'b1;
                if (d_illegal) begin
                    illegal = 1'b1;
                    state_d = ST_FETCH;
                end else if (d_jump || d_jal) begin
                    PCWrite = 1'b1;
                    NPCOp   = NPC_JUMP;
                    if (d_jal) begin
                        RegWrite = 1'b1;
                        GPRSel   = GPRSel_RA;
                        WDSel    = WDSel_PC;
                    end
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = (d_alu_r || d_branch) ? SRCB_RT : SRCB_IMM;
                ALUOp   = d_alu_op;
                EXTOp   = d_ext_op;
                AregSel = d_areg_sel;
                state_d = ST_FETCH;
                if (d_branch) begin
                    PCWrite = d_br_ne ? ~Zero : Zero;
                    NPCOp   = NPC_BR;
                    retire  = 1'b1;
                end else if (d_jr || d_jalr) begin
                    PCWrite = 1'b1;
                    NPCOp   = NPC_JREG;
                    if (d_jalr) begin
                        RegWrite = 1'b1;
                        GPRSel   = GPRSel_RA;
                        WDSel    = WDSel_PC;
                    end
                    retire = 1'b1;
                end else if (d_load) begin
                    state_d = ST_MEMRD;
                end else if (d_store) begin
                    state_d = ST_MEMWR;
                end else if (d_alu_r || d_alu_i) begin
                    state_d = ST_WB;
                end
            end
            ST_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                memOp   = d_mem_op;
                if (mem_ready) begin
                    state_d = ST_MEMWB;
                end else if (wait_tc) begin
                    bus_err = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                memOp    = d_mem_op;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else if (wait_tc) begin
                    bus_err = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_MEMWB: begin
                RegWrite = 1'b1;
                GPRSel   = GPRSel_RT;
                WDSel    = WDSel_MDR;
                retire   = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_WB: begin
                RegWrite = 1'b1;
                GPRSel   = d_alu_i ? GPRSel_RT : GPRSel_RD;
                WDSel    = WDSel_ALU;
                retire   = 1'b1;
                state_d  = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            instret   <= '0;
            wait_left <= WAIT_LOAD;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instret <= instret + CNT_W'(1);
            end
            // Reload whenever the wait ends: ready, timeout, or leaving memory states.
            if (is_mem_state(state_q) && !mem_ready && !wait_tc) begin
                wait_left <= wait_left - WAIT_W'(1);
            end else begin
                wait_left <= WAIT_LOAD;
            end
        end
    end

endmodule
